// File: rtl/pollard_pkg.sv
// pollard_pkg: shared types and constants for the Pollard p-1 sequencer.
//   state_e    - controller FSM states
//   *_DEF      - default operand/factor/index widths
//   FACTOR_TWO - factor reported for even n
package pollard_pkg;

  localparam int N_W_DEF = 64;
  localparam int F_W_DEF = 32;
  localparam int K_W_DEF = 8;

  localparam int FACTOR_TWO = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_EXP_REQ,
    S_EXP_WAIT,
    S_GCD_REQ,
    S_GCD_WAIT,
    S_EVAL,
    S_FINISH
  } state_e;

endpackage

// File: rtl/pollard_gcd_classify.sv
// pollard_gcd_classify: combinational verdict on a gcd result g against n.
//   g_i, n_i    - gcd value and modulus
//   trivial_o   - g == 1, keep iterating
//   overshoot_o - g >= n, all prime factors collapsed together
//   too_wide_o  - nontrivial factor that does not fit in F_W bits
//   valid_o     - nontrivial factor that fits in F_W bits
module pollard_gcd_classify #(
  parameter int N_W = 64,
  parameter int F_W = 32
) (
  input  logic [N_W-1:0] g_i,
  input  logic [N_W-1:0] n_i,
  output logic           trivial_o,
  output logic           overshoot_o,
  output logic           too_wide_o,
  output logic           valid_o
);

  logic in_range;
  logic hi_zero;

  assign in_range    = (g_i > N_W'(1)) && (g_i < n_i);
  assign hi_zero     = (g_i[N_W-1:F_W] == '0);
  assign trivial_o   = (g_i == N_W'(1));
  assign overshoot_o = (g_i >= n_i);
  assign too_wide_o  = in_range && !hi_zero;
  assign valid_o     = in_range && hi_zero;

endmodule

// File: rtl/pollard_ctrl.sv
// pollard_ctrl: restartable sequencer for Pollard p-1 factoring.
//   clk, rst_n          - clock, async active-low reset
//   start, n, bound     - request, number to factor, smoothness bound
//   busy, done          - in-progress flag, one-cycle completion pulse
//   found, prime1       - result, held until the next accepted start
//   exp_*               - handshake/operands to the modexp engine (a^k mod n)
//   gcd_*               - handshake/operands to the gcd engine (gcd(a-1, n))
module pollard_ctrl
  import pollard_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int F_W = F_W_DEF,
  parameter int K_W = K_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic [K_W-1:0] bound,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [F_W-1:0] prime1,
  output logic           exp_start,
  output logic [N_W-1:0] exp_base,
  output logic [N_W-1:0] exp_mod,
  output logic [K_W-1:0] exp_e,
  input  logic           exp_done,
  input  logic [N_W-1:0] exp_result,
  output logic           gcd_start,
  output logic [N_W-1:0] gcd_x,
  output logic [N_W-1:0] gcd_y,
  input  logic           gcd_done,
  input  logic [N_W-1:0] gcd_result
);

  state_e         state_q;
  logic [N_W-1:0] n_q, a_q, g_q;
  logic [K_W-1:0] bound_q, k_q;
  logic           busy_q, done_q, found_q;
  logic [F_W-1:0] prime1_q;
  logic           exp_start_q, gcd_start_q;
  logic [N_W-1:0] exp_base_q, exp_mod_q, gcd_x_q, gcd_y_q;
  logic [K_W-1:0] exp_e_q;
  logic           g_trivial, g_overshoot, g_too_wide, g_valid;

  pollard_gcd_classify #(.N_W(N_W), .F_W(F_W)) u_classify (
    .g_i        (g_q),
    .n_i        (n_q),
    .trivial_o  (g_trivial),
    .overshoot_o(g_overshoot),
    .too_wide_o (g_too_wide),
    .valid_o    (g_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      a_q         <= '0;
      g_q         <= '0;
      bound_q     <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      prime1_q    <= '0;
      exp_start_q <= 1'b0;
      gcd_start_q <= 1'b0;
      exp_base_q  <= '0;
      exp_mod_q   <= '0;
      exp_e_q     <= '0;
      gcd_x_q     <= '0;
      gcd_y_q     <= '0;
    end else begin
      // pulses default low; operands hold until the next request
      exp_start_q <= 1'b0;
      gcd_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          n_q      <= n;
          bound_q  <= bound;
          found_q  <= 1'b0;
          prime1_q <= '0;
          a_q      <= N_W'(2);
          k_q      <= K_W'(2);
          busy_q   <= 1'b1;
          state_q  <= S_CHECK;
        end
        S_CHECK: begin
          if (!n_q[0]) begin
            found_q  <= 1'b1;
            prime1_q <= F_W'(FACTOR_TWO);
            done_q   <= 1'b1;
            state_q  <= S_FINISH;
          end else if ((n_q < N_W'(4)) || (bound_q < K_W'(2))) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            exp_start_q <= 1'b1;
            exp_base_q  <= a_q;
            exp_e_q     <= k_q;
            exp_mod_q   <= n_q;
            state_q     <= S_EXP_REQ;
          end
        end
        S_EXP_REQ: state_q <= S_EXP_WAIT;
        S_EXP_WAIT: if (exp_done) begin
          a_q         <= exp_result;
          gcd_start_q <= 1'b1;
          // a == 0 would wrap a-1; n-1 gives the same gcd with n
          gcd_x_q     <= (exp_result == '0) ? n_q - N_W'(1) : exp_result - N_W'(1);
          gcd_y_q     <= n_q;
          state_q     <= S_GCD_REQ;
        end
        S_GCD_REQ: state_q <= S_GCD_WAIT;
        S_GCD_WAIT: if (gcd_done) begin
          g_q     <= gcd_result;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (g_valid) begin
            found_q  <= 1'b1;
            prime1_q <= g_q[F_W-1:0];
            done_q   <= 1'b1;
            state_q  <= S_FINISH;
          end else if (g_trivial && (k_q != bound_q)) begin
            // bound compared before increment, so k never wraps
            k_q         <= k_q + K_W'(1);
            exp_start_q <= 1'b1;
            exp_base_q  <= a_q;
            exp_e_q     <= k_q + K_W'(1);
            exp_mod_q   <= n_q;
            state_q     <= S_EXP_REQ;
          end else begin
            // overshoot, too wide, bound exhausted, or degenerate g == 0
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign prime1    = prime1_q;
  assign exp_start = exp_start_q;
  assign exp_base  = exp_base_q;
  assign exp_mod   = exp_mod_q;
  assign exp_e     = exp_e_q;
  assign gcd_start = gcd_start_q;
  assign gcd_x     = gcd_x_q;
  assign gcd_y     = gcd_y_q;

endmodule

// File: doc/pollard_ctrl.md
# pollard_ctrl

Sequencing controller for Pollard's p‑1 factorization of a 64‑bit odd composite. It drives an external modular‑exponentiation engine and an external GCD engine over start/done handshakes. It iterates a ← a^k mod n for k = 2..bound and tests gcd(a−1, n) after each step. It sits between the top‑level factorization wrapper (which supplies n and reads prime1) and the two arithmetic engines, and replaces free‑running sequencing with an explicit, restartable FSM.

## Interface
Parameters:
- N_W, 64, width of n and engine operands
- F_W, 32, width of reported factor prime1
- K_W, 8, width of iteration index k and bound

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active‑low reset
- start  in  1  one‑cycle request, accepted only in IDLE
- n  in  N_W  number to factor, sampled on accepted start
- bound  in  K_W  smoothness bound B, sampled on accepted start
- busy  out  1  high from accepted start until the done cycle (inclusive)
- done  out  1  one‑cycle completion pulse
- found  out  1  result valid flag, held until next accepted start
- prime1  out  F_W  factor found, held until next accepted start
- exp_start  out  1  one‑cycle request to exponentiation engine
- exp_base / exp_mod  out  N_W  operands a and n
- exp_e  out  K_W  exponent k
- exp_done  in  1  engine completion pulse
- exp_result  in  N_W  a^k mod n, valid with exp_done
- gcd_start  out  1  one‑cycle request to GCD engine
- gcd_x / gcd_y  out  N_W  operands a−1 and n
- gcd_done  in  1  engine completion pulse
- gcd_result  in  N_W  gcd, valid with gcd_done

## Operation
- States: IDLE, CHECK, EXP_REQ, EXP_WAIT, GCD_REQ, GCD_WAIT, EVAL, FINISH.
- IDLE: start → latch n and bound, clear found/prime1, set a=2 and k=2, go to CHECK.
- CHECK:
  - n[0]==0 → found=1, prime1=2, go to FINISH.
  - n<4 or bound<2 → found=0, go to FINISH.
  - Otherwise go to EXP_REQ.
- EXP_REQ: pulse exp_start with base=a, e=k, mod=n, then go to EXP_WAIT.
- EXP_WAIT: on exp_done, latch a=exp_result and go to GCD_REQ.
- GCD_REQ: pulse gcd_start with x=a−1 and y=n. If a==0, x=n−1 (no wrap). Then go to GCD_WAIT.
- GCD_WAIT: on gcd_done, latch g and go to EVAL.
- EVAL:
  - 1<g<n and g[N_W‑1:F_W]==0 → found=1, prime1=g[F_W‑1:0], go to FINISH.
  - g==n, or g too wide for F_W → found=0, go to FINISH.
  - g==1 and k==bound → found=0, go to FINISH.
  - g==1 otherwise → k=k+1, go to EXP_REQ.
- FINISH: done=1 for one cycle, then go to IDLE.
- k never wraps. The bound check precedes the increment, so bound=2^K_W−1 terminates.
- Exp/gcd operands are held stable from the start pulse until the matching done.

## Timing
- Reset values: busy=0, done=0, found=0, prime1=0, exp_start=0, gcd_start=0, all operand outputs 0. State is IDLE.
- Reset asserted mid‑operation aborts immediately. Engine done pulses after reset release are ignored.
- Accepted start → first exp_start: 2 cycles. Even n → done: 2 cycles.
- exp_done/gcd_done are sampled only in their WAIT states. Done pulses in any other state are ignored. Engines must take at least 1 cycle.
- EVAL → next exp_start: 2 cycles.
- start while busy: ignored, with no effect on latched n or bound. start in the FINISH cycle is also ignored.
- found/prime1 change only in CHECK and EVAL, and are stable when done is high.

## Structure
- Shared package pollard_pkg holds the state enum, N_W/F_W/K_W defaults, and the constant FACTOR_TWO.
- One natural sub‑module: pollard_gcd_classify. It is combinational, takes (g, n) and returns {trivial, overshoot, too_wide, valid}, and is used in EVAL.
- Engines are not instantiated here. The bench uses behavioral models with configurable latency.

## Test plan
- n=485, bound=10, engine latency 5 → exp runs for k=2,3,4. gcd values are 1, 1, 5. Result: done, found=1, prime1=5, exactly 3 exp_start pulses.
- n=486 → no exp_start. done 2 cycles after start, found=1, prime1=2.
- n=3 → done, found=0, no engine activity. Same for bound=1 with n=485.
- n=485, bound=3 → two iterations with g=1, then done with found=0 and k stopped at 3.
- n=97, bound=10 → at k=6, a=1 and gcd(0,97)=97. Result: done, found=0 (overshoot).
- Edge handling:
  - Assert rst_n low during EXP_WAIT → all outputs 0 and state IDLE.
  - A late exp_done is ignored.
  - A fresh start with n=485 then completes normally with prime1=5.
  - start pulses while busy are ignored.
